mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response bundle linking the fetch port, the load/store port and the shared
// single-port memory to the arbiter.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic        ls_we;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    // Arbiter view: serves both requesters, drives the memory command.
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_funct3, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    // Environment view: the two requesters plus the memory.
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_funct3, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between an instruction-fetch port and an RV32I load/store port
// sharing one single-port memory; one transaction is in flight at a time.
module mem_arbiter (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CMD, WAIT, RSP, ERR} state_e;
    typedef enum logic {OWN_IF, OWN_LS} owner_e;

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic        prio_ls_q, prio_ls_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        ls_rvalid_q, ls_rvalid_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        ls_err_q, ls_err_d;

    logic        grant_if, grant_ls, ls_illegal;
    logic [3:0]  store_be;
    logic [31:0] store_wdata, lane_word, load_data;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^bus.if_addr[1:0];

    // Grant is decided in the IDLE cycle itself so the requester drops its request on the next edge.
    always_comb begin
        grant_ls = !reset && (state_q == IDLE) && bus.ls_req && (!bus.if_req || prio_ls_q);
        grant_if = !reset && (state_q == IDLE) && bus.if_req && !grant_ls;
    end

    always_comb begin
        case (bus.ls_funct3)
            3'd0:       ls_illegal = 1'b0;
            3'd1:       ls_illegal = bus.ls_addr[0];
            3'd2:       ls_illegal = (bus.ls_addr[1:0] != 2'b00);
            3'd4, 3'd5: ls_illegal = bus.ls_we || (bus.ls_funct3[0] && bus.ls_addr[0]);
            default:    ls_illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (bus.ls_funct3[1:0])
            2'd0: begin
                store_be    = 4'b0001 << bus.ls_addr[1:0];
                store_wdata = {4{bus.ls_wdata[7:0]}};
            end
            2'd1: begin
                store_be    = 4'b0011 << bus.ls_addr[1:0];
                store_wdata = {2{bus.ls_wdata[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = bus.ls_wdata;
            end
        endcase
    end

    always_comb begin
        lane_word = bus.mem_rdata >> {offset_q, 3'b000};
        case (funct3_q)
            3'd0:    load_data = {{24{lane_word[7]}}, lane_word[7:0]};
            3'd1:    load_data = {{16{lane_word[15]}}, lane_word[15:0]};
            3'd4:    load_data = {24'd0, lane_word[7:0]};
            3'd5:    load_data = {16'd0, lane_word[15:0]};
            default: load_data = lane_word;
        endcase
    end

    always_comb begin
        // NOTE: every _d takes a default first, so no path through the case can infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        prio_ls_d   = prio_ls_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rvalid_d = 1'b0;
        ls_rdata_d  = ls_rdata_q;
        ls_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_ls) begin
                    owner_d   = OWN_LS;
                    prio_ls_d = 1'b0;
                    funct3_d  = bus.ls_funct3;
                    offset_d  = bus.ls_addr[1:0];
                    if (ls_illegal) begin
                        state_d     = ERR;
                        ls_rvalid_d = 1'b1;
                        ls_err_d    = 1'b1;
                        ls_rdata_d  = '0;
                    end else begin
                        state_d     = CMD;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.ls_we;
                        mem_addr_d  = {bus.ls_addr[31:2], 2'b00};
                        mem_be_d    = bus.ls_we ? store_be : 4'b1111;
                        mem_wdata_d = bus.ls_we ? store_wdata : '0;
                    end
                end else if (grant_if) begin
                    owner_d     = OWN_IF;
                    prio_ls_d   = 1'b1;
                    state_d     = CMD;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {bus.if_addr[31:2], 2'b00};
                    mem_be_d    = 4'b1111;
                    mem_wdata_d = '0;
                end
            end
            CMD: begin
                if (bus.mem_ready) begin
                    state_d   = WAIT;
                    mem_req_d = 1'b0;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d = RSP;
                    if (owner_q == OWN_IF) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = bus.mem_rdata;
                    end else begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = mem_we_q ? '0 : load_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            prio_ls_q   <= 1'b1;
            funct3_q    <= '0;
            offset_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= '0;
            ls_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            prio_ls_q   <= prio_ls_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_rdata_q  <= ls_rdata_d;
            ls_err_q    <= ls_err_d;
        end
    end

    assign bus.if_gnt    = grant_if;
    assign bus.ls_gnt    = grant_ls;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.ls_err    = ls_err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a byte-level memory image and a round-robin flag
// predict every grant, memory command and completion.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cycle = 0;

    mem_arbiter_if bus ();
    mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    bit          prio_ls;
    logic [7:0]  mem_b [logic [31:0]];
    bit          if_pend, ls_pend, ls_we_v;
    logic [2:0]  ls_f3_v;
    logic [31:0] if_a, ls_a, ls_wd;
    logic [2:0]  f3_tab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd7};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input logic [31:0] a);
        if (mem_b.exists(a)) return mem_b[a];
        return 8'(a * 37 + 11);
    endfunction

    function automatic logic [31:0] get_word(input logic [31:0] a);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = get_byte(a + 32'(j));
        return w;
    endfunction

    function automatic bit ls_is_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int size;
        bit legal;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        return !legal || ((int'(a[1:0]) % size) != 0);
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"}, {bus.if_gnt, bus.ls_gnt}, 32'd0);
        check({tag, "_rvalid"}, {bus.if_rvalid, bus.ls_rvalid, bus.ls_err}, 32'd0);
        check({tag, "_rdata"}, bus.if_rdata | bus.ls_rdata, 32'd0);
        check({tag, "_mem_ctl"}, {bus.mem_req, bus.mem_we, bus.mem_be}, 32'd0);
        check({tag, "_mem_bus"}, bus.mem_addr | bus.mem_wdata, 32'd0);
    endtask

    // One arbitration round, entered at the negedge of an IDLE cycle.
    task automatic serve(input int k, input int d);
        bit          win_ls, store, bad;
        int          size, t0;
        logic [31:0] a, exp_addr, exp_data, exp_wd, cmd_addr;
        logic [3:0]  exp_be;
        @(negedge clk);
        bus.if_req    = if_pend;
        bus.if_addr   = if_a;
        bus.ls_req    = ls_pend;
        bus.ls_we     = ls_we_v;
        bus.ls_funct3 = ls_f3_v;
        bus.ls_addr   = ls_a;
        bus.ls_wdata  = ls_wd;
        bus.mem_ready = 1'b0;
        bus.mem_rvalid = 1'b0;
        #1;
        check("idle_rvalid", {bus.if_rvalid, bus.ls_rvalid}, 32'd0);
        check("idle_mem_req", bus.mem_req, 32'd0);
        win_ls = ls_pend && (!if_pend || prio_ls);
        check("if_gnt", bus.if_gnt, 32'(!win_ls));
        check("ls_gnt", bus.ls_gnt, 32'(win_ls));
        prio_ls = !win_ls;
        t0    = cycle;
        a     = win_ls ? ls_a : if_a;
        store = win_ls && ls_we_v;
        size  = win_ls ? (1 << ls_f3_v[1:0]) : 4;
        bad   = win_ls && ls_is_err(ls_we_v, ls_f3_v, ls_a);

        @(negedge clk);
        if (win_ls) begin ls_pend = 1'b0; bus.ls_req = 1'b0; end
        else begin if_pend = 1'b0; bus.if_req = 1'b0; end
        #1;
        check("gnt_busy", {bus.if_gnt, bus.ls_gnt}, 32'd0);
        if (bad) begin
            check("err_rvalid", bus.ls_rvalid, 32'd1);
            check("err_flag", bus.ls_err, 32'd1);
            check("err_rdata", bus.ls_rdata, 32'd0);
            check("err_mem_req", bus.mem_req, 32'd0);
            check("err_if_rvalid", bus.if_rvalid, 32'd0);
            return;
        end

        exp_addr = a & ~32'd3;
        exp_be   = 4'b1111;
        exp_wd   = '0;
        if (store) begin
            exp_be = 4'b0000;
            for (int i = 0; i < size; i++) exp_be[int'(a[1:0]) + i] = 1'b1;
            for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = ls_wd[8*(j % size) +: 8];
        end
        check("cmd_req", bus.mem_req, 32'd1);
        check("cmd_we", bus.mem_we, 32'(store));
        check("cmd_be", bus.mem_be, 32'(exp_be));
        check("cmd_addr", bus.mem_addr, exp_addr);
        if (store) check("cmd_wdata", bus.mem_wdata, exp_wd);

        // Stalled CMD cycles also carry stray mem_rvalid pulses, which must be ignored.
        for (int i = 0; i <= k; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
                check("cmd_hold", {bus.mem_req, bus.mem_addr[31:2]}, {1'b1, exp_addr[31:2]});
            end
            bus.mem_ready  = (i == k);
            bus.mem_rvalid = (i < k) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_rdata  = $urandom;
        end
        cmd_addr = bus.mem_addr;

        @(negedge clk);
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        #1;
        check("wait_req", bus.mem_req, 32'd0);
        repeat (d) @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = get_word(cmd_addr);

        exp_data = 32'd0;
        if (!win_ls) begin
            exp_data = get_word(exp_addr);
        end else if (store) begin
            for (int i = 0; i < size; i++) mem_b[a + 32'(i)] = ls_wd[8*i +: 8];
        end else begin
            for (int i = 0; i < size; i++) exp_data |= 32'(get_byte(a + 32'(i))) << (8 * i);
            if (ls_f3_v < 3'd4 && size < 4 && exp_data[8*size-1])
                exp_data = exp_data - (32'd1 << (8 * size));
        end

        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
        #1;
        check("latency", 32'(cycle - t0), 32'(3 + k + d));
        check("if_rvalid", bus.if_rvalid, 32'(!win_ls));
        check("ls_rvalid", bus.ls_rvalid, 32'(win_ls));
        if (win_ls) begin
            check("ls_err", bus.ls_err, 32'd0);
            check("ls_rdata", bus.ls_rdata, exp_data);
        end else begin
            check("if_rdata", bus.if_rdata, exp_data);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.ls_req     = 1'b0;
        bus.ls_we      = 1'b0;
        bus.ls_funct3  = '0;
        bus.ls_addr    = '0;
        bus.ls_wdata   = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        prio_ls = 1'b1;
        if_pend = 1'b0;
        ls_pend = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_quiet("rst");
        reset = 1'b0;

        // Contention after reset: load/store first, then the fetch of 0x93 at 0x10.
        mem_b[32'h10] = 8'h93; mem_b[32'h11] = 8'h00; mem_b[32'h12] = 8'h00; mem_b[32'h13] = 8'h00;
        if_pend = 1'b1; if_a = 32'h10;
        ls_pend = 1'b1; ls_we_v = 1'b0; ls_f3_v = 3'd2; ls_a = 32'h120; ls_wd = '0;
        serve(0, 0);
        serve(0, 0);
        if_pend = 1'b1; if_a = 32'h104;
        ls_pend = 1'b1; ls_we_v = 1'b0; ls_f3_v = 3'd0; ls_a = 32'h105;
        serve(1, 0);
        serve(0, 1);

        // SB to the top lane, then LB/LBU and a misaligned LW.
        ls_pend = 1'b1; ls_we_v = 1'b1; ls_f3_v = 3'd0; ls_a = 32'h103; ls_wd = 32'h0000_00AB;
        serve(0, 0);
        mem_b[32'h100] = 8'h00; mem_b[32'h101] = 8'h00; mem_b[32'h102] = 8'h80; mem_b[32'h103] = 8'h00;
        ls_pend = 1'b1; ls_we_v = 1'b0; ls_f3_v = 3'd0; ls_a = 32'h102;
        serve(0, 0);
        ls_pend = 1'b1; ls_f3_v = 3'd4;
        serve(0, 0);
        ls_pend = 1'b1; ls_f3_v = 3'd2;
        serve(0, 0);

        for (int it = 0; it < 150; it++) begin
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1'b1;
                if_a    = 32'h100 + $urandom_range(0, 63);
            end
            if (!ls_pend && ($urandom_range(0, 2) != 0 || !if_pend)) begin
                ls_pend = 1'b1;
                ls_we_v = 1'($urandom_range(0, 1));
                ls_f3_v = f3_tab[$urandom_range(0, 9)];
                ls_a    = 32'h100 + $urandom_range(0, 63);
                ls_wd   = $urandom;
            end
            serve($urandom_range(0, 2), $urandom_range(0, 2));
        end
        for (int i = 0; i < 2; i++) if (if_pend || ls_pend) serve(0, 0);

        // Reset while waiting on memory: no completion may follow.
        @(negedge clk);
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_funct3 = 3'd2; bus.ls_addr = 32'h108;
        bus.if_req = 1'b0; bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
        #1;
        check("rw_gnt", bus.ls_gnt, 32'd1);
        @(negedge clk);
        bus.ls_req = 1'b0;
        repeat (3) @(negedge clk);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check("rw_wait_req", bus.mem_req, 32'd0);
        reset = 1'b1;
        #1;
        check_quiet("rw_async");
        @(negedge clk);
        reset = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        check("rw_no_rvalid", {bus.if_rvalid, bus.ls_rvalid}, 32'd0);
        prio_ls = 1'b1;

        if_pend = 1'b1; if_a = 32'h130;
        ls_pend = 1'b1; ls_we_v = 1'b1; ls_f3_v = 3'd1; ls_a = 32'h132; ls_wd = 32'h1234_BEEF;
        serve(0, 0);
        serve(1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
